fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//  Instruction-fetch stage between the PC/redirect logic and the IF/ID register.
//  Issues in-order word fetches to an instruction memory with variable latency (valid/ready request, valid response).
//  Buffers returned words in a small prefetch FIFO and presents one {pc, instr, pc+4} per cycle to decode.
//  Honours the hazard unit's decode stall and the execute-stage redirect (jump/taken branch); discards wrong-path fetches.
// PARAMETERS
//  DEPTH     4      prefetch FIFO entries; also the max in-flight + buffered words (power of 2, >=2)
//  RESET_PC  32'h0  fetch address after reset
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset: synchronous, active-high
//  redirect_valid   in   1   execute stage resolved jump/taken branch this cycle
//  redirect_pc      in   32  new fetch address (pc_target), word aligned
//  stall            in   1   decode stall; head entry is held
//  imem_req_valid   out  1   fetch request valid
//  imem_req_ready   in   1   memory accepts request
//  imem_req_addr    out  32  fetch address
//  imem_resp_valid  in   1   response word valid; responses return in request order
//  imem_resp_data   in   32  instruction word
//  out_valid        out  1   head entry valid
//  out_instr        out  32  head instruction; 32'h0000_0000 when !out_valid (bubble, same as IF/ID flush)
//  out_pc           out  32  head pc; 0 when !out_valid
//  out_pc_plus_4    out  32  out_pc + 4 (mod 2^32); 0 when !out_valid
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0.
//    All outputs 0; out_instr=0. First request asserted in the cycle after rst deasserts.
//  - Request: imem_req_valid = !redirect_valid && (occupancy + outstanding < DEPTH).
//    imem_req_addr = fetch_pc. On handshake: fetch_pc += 4, outstanding++.
//    The FIFO therefore never overflows.
//  - Response: outstanding--. If drop>0: drop--, word discarded. Else: push {pc, instr} to FIFO.
//    The pc is taken from a resp_pc register advanced by 4 per accepted response.
//  - Consume: pop when out_valid && !stall. Push and pop in the same cycle are both allowed, including with the FIFO full.
//    Output path: combinational from FIFO head.
//    Minimum latency: request handshake at cycle N with response at N+1 gives out_valid at N+2.
//  - Redirect (highest priority):
//    - FIFO cleared; pop suppressed that cycle.
//    - fetch_pc and resp_pc load redirect_pc.
//    - drop <= outstanding after this cycle's response is retired.
//    - No request that cycle; the next cycle fetches redirect_pc.
//    - A same-cycle response is discarded.
//    - Redirect during a nonzero drop (back-to-back redirects) re-arms drop using the same rule.
//  - Stall with FIFO not full: fetch continues until the credit limit is reached.
//    Stall with a redirect: redirect still flushes.
//  - Counters 0..DEPTH wide ($clog2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
//    pc arithmetic wraps at 2^32.
//  - Misaligned redirect_pc: bits [1:0] forced to 0.
//  - Reset mid-operation: all state is cleared, including drop.
//    Responses to pre-reset requests are the memory's responsibility; the memory resets on the same rst.
//  - Assertions: no push when full; no pop when empty; outstanding never underflows; imem_resp_valid only when outstanding>0.
// STRUCTURE
//  - fetch_pkg: typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t;
//    localparam logic [31:0] FETCH_BUBBLE = 32'h0;
//  - Sub-module sync_fifo #(.T(fetch_entry_t), .DEPTH) with synchronous clear.
//    Interfaces: push/pop/full/empty/count; head is visible combinationally.
//  - Top level holds fetch_pc, resp_pc, outstanding, drop, and request/credit logic.
// TESTING
//  1. Reset, 1-cycle memory, stall=0 -> requests 0,4,8,...; out_pc 0 at cycle 2, then +4 every cycle.
//     out_pc_plus_4 = out_pc + 4.
//  2. stall=1 for 10 cycles, DEPTH=4 -> exactly 4 words buffered+in-flight, req_valid drops.
//     Release -> 4 entries drain back to back, no gap, no duplicate.
//  3. 3-cycle memory latency, 3 in flight, redirect_pc=0x100 -> the 3 old responses are dropped.
//     First out_pc after the redirect is 0x100; out_valid=0 until then.
//  4. Redirect in the same cycle as resp_valid and as a pop -> the response is dropped and no pop occurs.
//     Next request addr=redirect_pc.
//  5. Two redirects 1 cycle apart (0x200, then 0x300) with 2 in flight -> all stale words dropped.
//     out_pc sequence starts 0x300,0x304.
//  6. imem_req_ready randomly low, resp jitter 1-5 cycles, 2000 cycles -> out_pc strictly +4 except at redirects.
//     Scoreboard matches the memory model; no assertion fires.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch buffer.
package fetch_pkg;

    // One decoded-stage slot: the fetched word and the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Value presented to decode when nothing valid is at the head (same as an IF/ID flush).
    localparam logic [31:0] FETCH_BUBBLE = 32'h0;

    // Sequential instruction stride.
    localparam logic [31:0] PC_STEP = 32'd4;

    // Instruction addresses are word aligned; low bits of a target are ignored.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer_sync_fifo.sv
// Small synchronous FIFO with a combinational head and a synchronous flush.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(pop && empty)) else $error("sync_fifo: pop while empty");
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; a push into a full FIFO is legal when the head pops in the same cycle.
    // NOTE: storage is deliberately not reset -- pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: issues in-order word fetches under a credit limit,
// buffers returned words, and presents {pc, instr, pc+4} to decode. Redirects
// flush the buffer and discard responses to wrong-path requests.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus_4
);

    localparam int          CW           = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   in_use;
    logic [31:0]   redirect_target;
    logic          req_fire;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  push_entry;
    fetch_entry_t  fifo_head;

    assign redirect_target = word_align(redirect_pc);

    // Buffered plus in-flight words may never exceed the FIFO size, so a response always has a slot.
    assign in_use         = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect_valid && (in_use < CREDIT_LIMIT);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A redirect discards the same-cycle response and blocks the pop; the FIFO is cleared anyway.
    assign fifo_push  = imem_resp_valid && !redirect_valid && (drop == '0);
    assign fifo_pop   = out_valid && !stall && !redirect_valid;
    assign push_entry = '{pc: resp_pc, instr: imem_resp_data};

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Fetch/response address tracking, in-flight count and wrong-path drop count.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            assert (!(imem_resp_valid && outstanding == '0))
                else $error("fetch_buffer: response with nothing outstanding");
            assert (!(fifo_push && fifo_full && !fifo_pop))
                else $error("fetch_buffer: push into full FIFO");

            case ({req_fire, imem_resp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                // Everything still in flight after this cycle's response belongs to the old path.
                drop     <= imem_resp_valid ? outstanding - 1'b1 : outstanding;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
                if (fifo_push)            resp_pc <= resp_pc + PC_STEP;
                else if (imem_resp_valid) drop    <= drop - 1'b1;
            end
        end
    end

    assign out_valid     = !fifo_empty;
    assign out_instr     = out_valid ? fifo_head.instr : FETCH_BUBBLE;
    assign out_pc        = out_valid ? fifo_head.pc : '0;
    assign out_pc_plus_4 = out_valid ? fifo_head.pc + PC_STEP : '0;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed and randomized bench for fetch_buffer with an in-order variable-latency memory model.
module tb_fetch_buffer;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus_4;

    int n_cmp = 0;
    int n_err = 0;

    fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc_plus_4   (out_pc_plus_4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: a fixed scramble of the address so pc/instr pairing is checkable.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hC0DE_0000;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    mem_cyc = 0;
    int    lat_min = 1;
    int    lat_max = 1;
    bit    rdy_random = 1'b0;

    // In-order memory: a request accepted in cycle N answers no earlier than cycle N+lat.
    initial begin
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            mem_cyc++;
            if (rst) pend.delete();
            else if (imem_req_valid && imem_req_ready)
                pend.push_back('{addr: imem_req_addr,
                                 due: mem_cyc - 1 + int'($urandom_range(lat_max, lat_min))});
            #1;
            if (!rst && pend.size() > 0 && pend[0].due <= mem_cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
            end
            imem_req_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_pc"},    out_pc,         v ? pc : 32'h0);
        check({tag, "_pc4"},   out_pc_plus_4,  v ? pc + 32'd4 : 32'h0);
        check({tag, "_instr"}, out_instr,      v ? mem_word(pc) : 32'h0);
    endtask

    task automatic check_req(input string tag, input logic v, input logic [31:0] addr);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'(v));
        if (v) check({tag, "_req_addr"}, imem_req_addr, addr);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Holds rst for two edges, checks the reset state, and returns at the start of cycle 0.
    task automatic do_reset(input int lat);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        lat_min        = lat;
        lat_max        = lat;
        next_cycle();
        #1;
        check_out("rst", 1'b0, 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        next_cycle();
        rst = 1'b0;
    endtask

    int          pops;
    logic [31:0] exp_pc;
    logic [31:0] r;

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;

        // 1: streaming with a 1-cycle memory
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next_cycle();
            #1;
            check_req($sformatf("t1_c%0d", k), 1'b1, 32'(4 * k));
            check_out($sformatf("t1_c%0d", k), k >= 2, 32'(4 * (k - 2)));
        end

        // 2: decode stall fills the credit window, release drains without gaps
        next_cycle();
        stall = 1'b1;
        for (int k = 8; k < 18; k++) begin
            if (k > 8) next_cycle();
            #1;
            check_out($sformatf("t2_hold_c%0d", k), 1'b1, 32'd24);
            check(    $sformatf("t2_req_c%0d", k), 32'(imem_req_valid), 32'(k < 10));
        end
        next_cycle();
        stall = 1'b0;
        for (int k = 18; k < 23; k++) begin
            if (k > 18) next_cycle();
            #1;
            check_out($sformatf("t2_drain_c%0d", k), 1'b1, 32'(24 + 4 * (k - 18)));
            if (k == 18) check_req("t2_c18", 1'b0, 32'h0);
            if (k == 19) check_req("t2_c19", 1'b1, 32'd40);
        end

        // 3: reset mid-stream, 3-cycle memory, redirect with 3 in flight
        do_reset(3);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) next_cycle();
            redirect_valid = (k == 3);
            redirect_pc    = 32'h100;
            #1;
            if (k < 3)  check_req($sformatf("t3_c%0d", k), 1'b1, 32'(4 * k));
            if (k == 3) check_req("t3_c3", 1'b0, 32'h0);
            if (k == 4) check_req("t3_c4", 1'b1, 32'h100);
            check_out($sformatf("t3_c%0d", k), k >= 8, 32'h100 + 32'(4 * (k - 8)));
        end
        redirect_valid = 1'b0;

        // 4: redirect coincides with a response and a pop; misaligned target
        do_reset(1);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) next_cycle();
            redirect_valid = (k == 4);
            redirect_pc    = 32'h182;
            #1;
            if (k < 4)  check_req($sformatf("t4_c%0d", k), 1'b1, 32'(4 * k));
            if (k == 4) check_req("t4_c4", 1'b0, 32'h0);
            if (k == 5) check_req("t4_c5", 1'b1, 32'h180);
            if (k == 6) check_req("t4_c6", 1'b1, 32'h184);
            if (k >= 2 && k <= 4)  check_out($sformatf("t4_c%0d", k), 1'b1, 32'(4 * (k - 2)));
            if (k == 5 || k == 6)  check_out($sformatf("t4_c%0d", k), 1'b0, 32'h0);
            if (k >= 7)            check_out($sformatf("t4_c%0d", k), 1'b1, 32'h180 + 32'(4 * (k - 7)));
        end
        redirect_valid = 1'b0;

        // 5: back-to-back redirects with 2 in flight, 3-cycle memory
        do_reset(3);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) next_cycle();
            redirect_valid = (k == 2) || (k == 3);
            redirect_pc    = (k == 2) ? 32'h200 : 32'h300;
            #1;
            if (k < 2)             check_req($sformatf("t5_c%0d", k), 1'b1, 32'(4 * k));
            if (k == 2 || k == 3)  check_req($sformatf("t5_c%0d", k), 1'b0, 32'h0);
            if (k == 4)            check_req("t5_c4", 1'b1, 32'h300);
            if (k == 5)            check_req("t5_c5", 1'b1, 32'h304);
            check_out($sformatf("t5_c%0d", k), k >= 8, 32'h300 + 32'(4 * (k - 8)));
        end
        redirect_valid = 1'b0;

        // 6: random ready, 1-5 cycle jitter, random stalls and redirects
        do_reset(1);
        lat_min    = 1;
        lat_max    = 5;
        rdy_random = 1'b1;
        exp_pc     = 32'h0;
        pops       = 0;
        for (int k = 0; k < 2000; k++) begin
            if (k > 0) next_cycle();
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 49) == 0);
            r              = $urandom;
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : r;
            #1;
            if (out_valid && !stall && !redirect_valid) begin
                check("t6_pc",    out_pc,        exp_pc);
                check("t6_instr", out_instr,     mem_word(exp_pc));
                check("t6_pc4",   out_pc_plus_4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
        end
        check("t6_progress", 32'(pops > 200), 32'd1);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        rdy_random     = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
